// File: rtl/prio_arb8_ctrl.sv
// rtl/prio_arb8_ctrl.sv - 8-requester arbiter, fixed-MSB or round-robin priority, hold timeout
//
// Ports:
//   clk       - clock, all state updates on posedge
//   rst_n     - synchronous active-low reset
//   mode      - 0 = fixed priority (index 7 highest), 1 = round-robin; sampled at arbitration
//   req[7:0]  - request vector, owner keeps its bit high while using the resource
//   done      - owner release pulse, only honoured while a grant is active
//   gnt[7:0]  - registered one-hot grant
//   gnt_id    - registered encoded owner index, valid with gnt_valid
//   gnt_valid - high while a grant is active
//   timeout   - one-cycle pulse after a grant is revoked by the hold limit
//   busy      - high whenever the arbiter is not idle

module prio_arb8_ctrl #(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       mode,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] gnt,
    output logic [2:0] gnt_id,
    output logic       gnt_valid,
    output logic       timeout,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = (MAX_HOLD > 0) ? CNT_W'(MAX_HOLD - 1) : '0;
    localparam logic             HOLD_EN   = (MAX_HOLD > 0);

    state_t           state, state_d;
    logic [7:0]       gnt_d;
    logic [2:0]       gnt_id_d;
    logic             gnt_valid_d;
    logic             timeout_d;
    logic [2:0]       rr_ptr, rr_ptr_d;
    logic [CNT_W-1:0] hold_cnt, hold_cnt_d;
    logic [2:0]       winner;
    logic             rel_done, rel_drop, rel_to;

    // Fixed mode keeps the highest set index. Round-robin scans offsets
    // 7 down to 0 from rr_ptr so the last hit is the closest one to rr_ptr.
    function automatic logic [2:0] pick(input logic [7:0] r, input logic m, input logic [2:0] p);
        logic [2:0] w;
        logic [2:0] idx;
        w = 3'd0;
        if (!m) begin
            for (int i = 0; i < 8; i++) begin
                if (r[i]) w = 3'(i);
            end
        end else begin
            for (int i = 7; i >= 0; i--) begin
                idx = p + 3'(i);
                if (r[idx]) w = idx;
            end
        end
        return w;
    endfunction

    assign winner   = pick(req, mode, rr_ptr);
    assign rel_done = done;
    assign rel_drop = !req[gnt_id];
    assign rel_to   = HOLD_EN && (hold_cnt == HOLD_LAST);
    assign busy     = (state != IDLE);

    always_comb begin
        state_d     = state;
        gnt_d       = gnt;
        gnt_id_d    = gnt_id;
        gnt_valid_d = gnt_valid;
        timeout_d   = 1'b0;
        rr_ptr_d    = rr_ptr;
        hold_cnt_d  = hold_cnt;
        case (state)
            IDLE: begin
                if (req != 8'd0) begin
                    gnt_d       = 8'd1 << winner;
                    gnt_id_d    = winner;
                    gnt_valid_d = 1'b1;
                    hold_cnt_d  = '0;
                    rr_ptr_d    = winner + 3'd1;
                    state_d     = BUSY;
                end
            end
            BUSY: begin
                if (rel_done || rel_drop || rel_to) begin
                    gnt_d       = 8'd0;
                    gnt_valid_d = 1'b0;
                    // An owner-initiated release wins over a coincident timeout.
                    timeout_d   = rel_to && !rel_done && !rel_drop;
                    state_d     = GAP;
                end else begin
                    hold_cnt_d  = hold_cnt + CNT_W'(1);
                end
            end
            GAP: begin
                gnt_d       = 8'd0;
                gnt_valid_d = 1'b0;
                state_d     = IDLE;
            end
            default: begin
                gnt_d       = 8'd0;
                gnt_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            gnt       <= 8'd0;
            gnt_id    <= 3'd0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
            rr_ptr    <= 3'd0;
            hold_cnt  <= '0;
        end else begin
            state     <= state_d;
            gnt       <= gnt_d;
            gnt_id    <= gnt_id_d;
            gnt_valid <= gnt_valid_d;
            timeout   <= timeout_d;
            rr_ptr    <= rr_ptr_d;
            hold_cnt  <= hold_cnt_d;
        end
    end

endmodule

// File: tb/tb_prio_arb8_ctrl.sv
// tb/tb_prio_arb8_ctrl.sv - directed self-checking bench for prio_arb8_ctrl

module tb_prio_arb8_ctrl;

    logic       clk;
    logic       rst_n;
    logic       mode;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       gnt_valid;
    logic       timeout;
    logic       busy;

    int nvec;
    int nerr;

    prio_arb8_ctrl #(.MAX_HOLD(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .timeout   (timeout),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; inputs driven and outputs sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic quiesce();
        req  = 8'd0;
        done = 1'b0;
        repeat (3) step();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 8'd0;
        done  = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req = 8'd0; done = 1'b0; mode = 1'b0;
        step(); step();
        nvec++; if (gnt !== 8'd0)      begin nerr++; $display("FAIL reset_gnt: got %h want 00", gnt); end
        nvec++; if (gnt_id !== 3'd0)   begin nerr++; $display("FAIL reset_id: got %0d want 0", gnt_id); end
        nvec++; if (gnt_valid !== 1'b0) begin nerr++; $display("FAIL reset_valid: got %b want 0", gnt_valid); end
        nvec++; if (timeout !== 1'b0)  begin nerr++; $display("FAIL reset_timeout: got %b want 0", timeout); end
        nvec++; if (busy !== 1'b0)     begin nerr++; $display("FAIL reset_busy: got %b want 0", busy); end
        rst_n = 1'b1;
        req = 8'h20;
        step();
        nvec++; if (gnt !== 8'h20)     begin nerr++; $display("FAIL pre_reset_gnt: got %h want 20", gnt); end
        rst_n = 1'b0;
        step();
        nvec++; if (gnt !== 8'd0)      begin nerr++; $display("FAIL midgrant_gnt: got %h want 00", gnt); end
        nvec++; if (gnt_valid !== 1'b0) begin nerr++; $display("FAIL midgrant_valid: got %b want 0", gnt_valid); end
        nvec++; if (busy !== 1'b0)     begin nerr++; $display("FAIL midgrant_busy: got %b want 0", busy); end
        // rr_ptr must restart at 0: with pointer 6 left over, 0x41 would pick 6.
        rst_n = 1'b1; mode = 1'b1; req = 8'h41;
        step();
        nvec++; if (gnt_id !== 3'd0)   begin nerr++; $display("FAIL post_reset_id: got %0d want 0", gnt_id); end
        nvec++; if (gnt !== 8'h01)     begin nerr++; $display("FAIL post_reset_gnt: got %h want 01", gnt); end
        quiesce();
    endtask

    task automatic test_fixed();
        mode = 1'b0; req = 8'b0010_0110;
        step();
        nvec++; if (gnt !== 8'b0010_0000) begin nerr++; $display("FAIL fixed_gnt: got %h want 20", gnt); end
        nvec++; if (gnt_id !== 3'd5)      begin nerr++; $display("FAIL fixed_id: got %0d want 5", gnt_id); end
        nvec++; if (busy !== 1'b1)        begin nerr++; $display("FAIL fixed_busy: got %b want 1", busy); end
        done = 1'b1; req = 8'b0000_0110;
        step();
        done = 1'b0;
        nvec++; if (gnt !== 8'd0)         begin nerr++; $display("FAIL fixed_rel_gnt: got %h want 00", gnt); end
        nvec++; if (timeout !== 1'b0)     begin nerr++; $display("FAIL fixed_rel_to: got %b want 0", timeout); end
        step();
        nvec++; if (gnt_valid !== 1'b0)   begin nerr++; $display("FAIL fixed_gap2_valid: got %b want 0", gnt_valid); end
        nvec++; if (busy !== 1'b0)        begin nerr++; $display("FAIL fixed_idle_busy: got %b want 0", busy); end
        step();
        nvec++; if (gnt_id !== 3'd2)      begin nerr++; $display("FAIL fixed_second_id: got %0d want 2", gnt_id); end
        nvec++; if (gnt !== 8'h04)        begin nerr++; $display("FAIL fixed_second_gnt: got %h want 04", gnt); end
        quiesce();
    endtask

    task automatic test_round_robin();
        logic [7:0] exp_g;
        do_reset();
        mode = 1'b1; req = 8'hFF;
        for (int i = 0; i < 9; i++) begin
            step();
            exp_g = 8'd1 << (i % 8);
            nvec++; if (gnt_id !== 3'(i % 8)) begin nerr++; $display("FAIL rr_id[%0d]: got %0d want %0d", i, gnt_id, i % 8); end
            nvec++; if (gnt !== exp_g)        begin nerr++; $display("FAIL rr_gnt[%0d]: got %h want %h", i, gnt, exp_g); end
            done = 1'b1;
            step();
            done = 1'b0;
            step();
        end
        mode = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            nvec++; if (gnt_id !== 3'd7) begin nerr++; $display("FAIL fixed_ff_id[%0d]: got %0d want 7", i, gnt_id); end
            done = 1'b1;
            step();
            done = 1'b0;
            step();
        end
        quiesce();
    endtask

    task automatic test_timeout();
        logic [2:0] exp_ids [3];
        exp_ids[0] = 3'd0; exp_ids[1] = 3'd3; exp_ids[2] = 3'd0;
        do_reset();
        mode = 1'b1; req = 8'b0000_1001;
        for (int g = 0; g < 3; g++) begin
            for (int c = 0; c < 4; c++) begin
                step();
                nvec++; if (gnt_valid !== 1'b1 || gnt_id !== exp_ids[g] || timeout !== 1'b0)
                    begin nerr++; $display("FAIL to_hold[%0d][%0d]: got v=%b id=%0d to=%b want v=1 id=%0d to=0", g, c, gnt_valid, gnt_id, timeout, exp_ids[g]); end
            end
            step();
            nvec++; if (timeout !== 1'b1 || gnt !== 8'd0)
                begin nerr++; $display("FAIL to_pulse[%0d]: got to=%b gnt=%h want to=1 gnt=00", g, timeout, gnt); end
            step();
            nvec++; if (timeout !== 1'b0 || gnt_valid !== 1'b0)
                begin nerr++; $display("FAIL to_clear[%0d]: got to=%b v=%b want to=0 v=0", g, timeout, gnt_valid); end
        end
        quiesce();
    endtask

    task automatic test_precedence();
        mode = 1'b0; req = 8'h10;
        step();
        nvec++; if (gnt_id !== 3'd4) begin nerr++; $display("FAIL prec_id: got %0d want 4", gnt_id); end
        req = 8'h00;
        step();
        nvec++; if (gnt !== 8'd0 || timeout !== 1'b0)
            begin nerr++; $display("FAIL prec_drop: got gnt=%h to=%b want gnt=00 to=0", gnt, timeout); end
        step(); step();
        req = 8'h10;
        step();
        step(); step(); step();
        nvec++; if (gnt !== 8'h10) begin nerr++; $display("FAIL prec_held: got %h want 10", gnt); end
        done = 1'b1;
        step();
        done = 1'b0;
        nvec++; if (gnt !== 8'd0 || timeout !== 1'b0)
            begin nerr++; $display("FAIL prec_done_at_limit: got gnt=%h to=%b want gnt=00 to=0", gnt, timeout); end
        quiesce();
    endtask

    task automatic test_idle_robust();
        logic [7:0] others [3];
        others[0] = 8'h80; others[1] = 8'h41; others[2] = 8'hFC;
        req = 8'd0;
        for (int i = 0; i < 4; i++) begin
            done = i[0];
            step();
            nvec++; if (gnt !== 8'd0 || gnt_valid !== 1'b0 || busy !== 1'b0 || timeout !== 1'b0)
                begin nerr++; $display("FAIL idle_done[%0d]: got gnt=%h v=%b busy=%b to=%b want all 0", i, gnt, gnt_valid, busy, timeout); end
        end
        done = 1'b0; mode = 1'b0; req = 8'h02;
        step();
        nvec++; if (gnt_id !== 3'd1) begin nerr++; $display("FAIL busy_grant_id: got %0d want 1", gnt_id); end
        for (int i = 0; i < 3; i++) begin
            mode = ~mode;
            req  = 8'h02 | others[i];
            step();
            nvec++; if (gnt !== 8'h02 || gnt_id !== 3'd1)
                begin nerr++; $display("FAIL busy_stable[%0d]: got gnt=%h id=%0d want gnt=02 id=1", i, gnt, gnt_id); end
        end
        quiesce();
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        rst_n = 1'b0; mode = 1'b0; req = 8'd0; done = 1'b0;
        test_reset();
        test_fixed();
        test_round_robin();
        test_timeout();
        test_precedence();
        test_idle_robust();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/prio_arb8_ctrl.md
Name: prio_arb8_ctrl

Overview:
Sequential arbiter that shares one resource among 8 requesters, using the same 8-way priority selection as the team's 8:3 priority encoders.
- Mode 0: fixed priority, MSB (index 7) highest.
- Mode 1: round-robin.
- Grants are registered, held until the owner releases or a hold timeout fires, and separated by one dead cycle.
- Sits between requester agents and the shared resource; drives one-hot grant plus encoded owner ID.

Parameters:
MAX_HOLD, 16, max cycles a grant may be held; 0 disables the timeout.
CNT_W, $clog2(MAX_HOLD+1) (min 1), width of the hold counter.

Ports:
clk  input  1  single clock; all state updates on posedge.
rst_n  input  1  synchronous active-low reset, sampled on posedge clk.
mode  input  1  0 = fixed MSB priority, 1 = round-robin; sampled only at arbitration.
req  input  8  request vector; a requester holds its bit high while it wants or uses the resource.
done  input  1  owner's release pulse; meaningful only in BUSY.
gnt  output  8  one-hot grant, registered.
gnt_id  output  3  encoded owner index, registered; valid when gnt_valid=1.
gnt_valid  output  1  high while a grant is active.
timeout  output  1  one-cycle pulse when a grant is revoked by the hold limit.
busy  output  1  high when state != IDLE.

Behaviour:
- Reset (rst_n=0 at posedge, any state):
  - state=IDLE; gnt=0, gnt_id=0, gnt_valid=0, timeout=0.
  - rr_ptr=0, hold_cnt=0.
  - Reset mid-grant revokes the grant at that edge.
- States: IDLE, BUSY, GAP.
- IDLE:
  - req=0 → stay IDLE.
  - req!=0 at posedge N → winner chosen from req sampled at N.
  - Same edge: gnt=onehot(winner), gnt_id=winner, gnt_valid=1, hold_cnt=0, state=BUSY.
  - Latency: request sampled → grant visible after one edge.
- Winner selection:
  - Fixed (mode=0): highest set index.
  - Round-robin (mode=1): first set bit scanning rr_ptr, rr_ptr+1, …, 7, 0, … (wraps mod 8).
  - On every grant, in either mode: rr_ptr = (winner+1) mod 8.
- BUSY: hold_cnt increments each cycle; release conditions are evaluated each posedge.
  - (a) done=1
  - (b) req[gnt_id]=0 (owner dropped)
  - (c) MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1 (timeout)
  - On any release: gnt=0, gnt_valid=0 at that edge; state=GAP.
  - timeout=1 for exactly one cycle only if (c) holds and neither (a) nor (b) does; (a)/(b) take precedence.
  - Grant lasts at most MAX_HOLD cycles of gnt_valid=1.
  - Changes to non-owner req bits and to mode have no effect during BUSY.
- GAP:
  - Outputs idle, timeout cleared; next edge → IDLE unconditionally.
  - Minimum spacing: release edge → GAP → IDLE → next grant, i.e. two cycles with gnt_valid=0 between grants.
- done outside BUSY is ignored.
- gnt always one-hot or zero; gnt_id always matches gnt when gnt_valid=1.
- busy is combinational from state.

Test Plan:
1. Reset mid-grant: gnt=8'h20 active, drive rst_n=0 one cycle → next edge gnt=0, gnt_valid=0, busy=0; after release, req=8'h01 grants id 0 (rr_ptr=0).
2. Fixed priority, mode=0, req=8'b0010_0110 → one edge later gnt=8'b0010_0000, gnt_id=5. Pulse done, req becomes 8'b0000_0110 → gnt=0, two idle cycles, then gnt_id=2.
3. Round-robin, mode=1, req=8'hFF constant, done pulsed one cycle after each grant → gnt_id sequence 0,1,2,…,7,0. Same stimulus with mode=0 → 7 every time.
4. Timeout, MAX_HOLD=4, mode=1, req=8'b0000_1001, no done:
   - gnt_id=0 for exactly 4 cycles, then timeout=1 for one cycle with gnt=0.
   - Next grant gnt_id=3; after it times out, gnt_id=0 again.
5. Release precedence:
   - Owner drops req bit → released with timeout=0.
   - done=1 on the same cycle hold_cnt==MAX_HOLD-1 → released with timeout=0.
6. Idle robustness: req=0 with done pulses → stays IDLE, all outputs 0. Toggling mode and non-owner req bits during BUSY → gnt unchanged.
